// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Requesters are served round-robin. A requester may lock the bus for up to
// BURST_MAX consecutive beats. Read data returns one cycle after the grant.
module data_mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0_valid,
    input  logic          req0_wen,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req0_lock,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1_valid,
    input  logic          req1_wen,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    input  logic          req1_lock,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wen,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t        state;
    logic [3:0]    count;
    logic          last;

    logic          any_gnt;
    logic          win_wen;
    logic          win_lock;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          continuing;
    logic [3:0]    beat_count;
    logic          burst_done;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rvalid0_q;
    logic          rvalid1_q;

    // Grant decision: a burst owner keeps the bus while it still requests; otherwise round-robin against last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (state == OWN0 && req0_valid && count < BURST_LIM) begin
                gnt0 = 1'b1;
            end else if (state == OWN1 && req1_valid && count < BURST_LIM) begin
                gnt1 = 1'b1;
            end else if (req0_valid && req1_valid) begin
                if (last) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Select the winning request fields and work out the beat number within the current burst.
    always_comb begin
        any_gnt    = gnt0 | gnt1;
        win_wen    = gnt1 ? req1_wen   : req0_wen;
        win_lock   = gnt1 ? req1_lock  : req0_lock;
        win_addr   = gnt1 ? req1_addr  : req0_addr;
        win_wdata  = gnt1 ? req1_wdata : req0_wdata;
        continuing = (state == OWN0 && gnt0) || (state == OWN1 && gnt1);
        beat_count = continuing ? count + 4'd1 : 4'd1;
        burst_done = beat_count >= BURST_LIM;
    end

    // Ownership FSM: stay with the winner while it locks and the burst limit is not reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 4'd0;
            last  <= 1'b1;
        end else if (any_gnt) begin
            last <= gnt1;
            if (win_lock && !burst_done) begin
                state <= gnt1 ? OWN1 : OWN0;
                count <= beat_count;
            end else begin
                state <= IDLE;
                count <= 4'd0;
            end
        end else begin
            state <= IDLE;
            count <= 4'd0;
        end
    end

    // Remember the last driven address/data so the memory bus holds steady between beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_gnt) begin
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
        end
    end

    // Flag which requester gets read data on the cycle after its granted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~req0_wen;
            rvalid1_q <= gnt1 & ~req1_wen;
        end
    end

    assign mem_addr  = any_gnt ? win_addr  : addr_q;
    assign mem_wdata = any_gnt ? win_wdata : wdata_q;
    assign mem_wen   = any_gnt & win_wen;

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? mem_rdata : '0;
    assign rdata1  = rvalid1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by random traffic.
// Expected behaviour comes from a behavioural model with an owner, a beat count and a shadow memory.
module tb_data_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        v [2];
    logic        w [2];
    logic        lk [2];
    logic [31:0] a [2];
    logic [31:0] d [2];

    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wen;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int errors  = 0;

    // Model state
    int          owner;
    int          beats;
    int          last;
    int          last_g;
    logic [31:0] shadow [64];
    logic        pend [2];
    logic [31:0] pend_data [2];
    logic [31:0] last_addr;
    logic [31:0] last_wdata;

    logic [31:0] mem [64];
    bit          mem_loaded = 1'b0;

    data_mem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v[0]), .req0_wen(w[0]), .req0_addr(a[0]), .req0_wdata(d[0]), .req0_lock(lk[0]),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1_valid(v[1]), .req1_wen(w[1]), .req1_addr(a[1]), .req1_wdata(d[1]), .req1_lock(lk[1]),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Memory with registered read data, preloaded on the first clock
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_wen) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[5:0]];
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Who should win this cycle, from the current requests and model state
    function automatic int pick();
        if (owner >= 0 && v[owner]) return owner;
        if (v[0] && v[1]) return (last == 0) ? 1 : 0;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic modelReset();
        owner      = -1;
        beats      = 0;
        last       = 1;
        last_g     = -1;
        pend[0]    = 1'b0;
        pend[1]    = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
    endtask

    // Sample at the falling edge, compare with the model, then advance the model by one cycle
    task automatic applyStimulus();
        int          g;
        int          run;
        logic [31:0] ea, ed;
        logic        ew;
        @(negedge clk);
        g = pick();
        checkOutput("gnt0", 64'(gnt0), 64'(g == 0));
        checkOutput("gnt1", 64'(gnt1), 64'(g == 1));
        if (g >= 0) begin
            ea = a[g];
            ed = d[g];
            ew = w[g];
            last_addr  = a[g];
            last_wdata = d[g];
        end else begin
            ea = last_addr;
            ed = last_wdata;
            ew = 1'b0;
        end
        checkOutput("mem_wen", 64'(mem_wen), 64'(ew));
        checkOutput("mem_addr", 64'(mem_addr), 64'(ea));
        checkOutput("mem_wdata", 64'(mem_wdata), 64'(ed));
        checkOutput("rvalid0", 64'(rvalid0), 64'(pend[0]));
        checkOutput("rvalid1", 64'(rvalid1), 64'(pend[1]));
        checkOutput("rdata0", 64'(rdata0), 64'(pend[0] ? pend_data[0] : 32'h0));
        checkOutput("rdata1", 64'(rdata1), 64'(pend[1] ? pend_data[1] : 32'h0));
        for (int n = 0; n < 2; n++) begin
            pend[n] = (g == n) && !w[n];
            if (pend[n]) pend_data[n] = shadow[a[n][5:0]];
        end
        if (g >= 0 && w[g]) shadow[a[g][5:0]] = d[g];
        if (g >= 0) begin
            run  = (owner == g) ? beats + 1 : 1;
            last = g;
            if (lk[g] && run < BURST_MAX) begin
                owner = g;
                beats = run;
            end else begin
                owner = -1;
                beats = 0;
            end
        end else begin
            owner = -1;
            beats = 0;
        end
        last_g = g;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearRequests();
        for (int n = 0; n < 2; n++) begin
            v[n]  = 1'b0;
            w[n]  = 1'b0;
            lk[n] = 1'b0;
        end
    endtask

    // Assert reset, check the reset values, then release it just after a rising edge
    task automatic doReset(input int hold);
        reset = 1'b0;
        clearRequests();
        modelReset();
        @(negedge clk);
        checkOutput("rst_rvalid0", 64'(rvalid0), 64'h0);
        checkOutput("rst_rvalid1", 64'(rvalid1), 64'h0);
        checkOutput("rst_mem_wen", 64'(mem_wen), 64'h0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        repeat (hold) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic setReq(input int n, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        v[n]  = 1'b1;
        w[n]  = wen;
        a[n]  = addr;
        d[n]  = wdata;
        lk[n] = lock;
    endtask

    // Random requesters: a granted request retires, idle requesters may raise a new one
    task automatic randomRequests();
        for (int n = 0; n < 2; n++) begin
            if (last_g == n) v[n] = 1'b0;
            if (!v[n] && $urandom_range(0, 9) < 7) begin
                setReq(n, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                       1'($urandom_range(0, 2) != 0));
            end
        end
    endtask

    logic [6:0] exp0_pat;
    logic [6:0] exp1_pat;
    int         beats0;

    initial begin
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            a[n] = '0;
            d[n] = '0;
        end
        for (int i = 0; i < 64; i++) shadow[i] = seed_word(i);
        doReset(2);

        // Tie after reset goes to requester 0, then requester 1, reads return in order
        setReq(0, 1'b0, 32'h10, 32'h0, 1'b0);
        setReq(1, 1'b0, 32'h20, 32'h0, 1'b0);
        applyStimulus();
        checkOutput("d036_c1_gnt0", 64'(gnt0), 64'h1);
        checkOutput("d036_c1_gnt1", 64'(gnt1), 64'h0);
        nextCycle();
        v[0] = 1'b0;
        applyStimulus();
        checkOutput("d036_c2_gnt1", 64'(gnt1), 64'h1);
        checkOutput("d036_c2_rvalid0", 64'(rvalid0), 64'h1);
        checkOutput("d036_c2_rdata0", 64'(rdata0), 64'(seed_word(16)));
        nextCycle();
        v[1] = 1'b0;
        applyStimulus();
        checkOutput("d036_c3_rvalid1", 64'(rvalid1), 64'h1);
        checkOutput("d036_c3_rdata1", 64'(rdata1), 64'(seed_word(32)));
        nextCycle();

        // Write then read-back of the same word on consecutive cycles
        setReq(0, 1'b1, 32'h5, 32'hDEAD_BEEF, 1'b0);
        applyStimulus();
        checkOutput("d037_wr_mem_wen", 64'(mem_wen), 64'h1);
        nextCycle();
        v[0] = 1'b0;
        setReq(1, 1'b0, 32'h5, 32'h0, 1'b0);
        applyStimulus();
        checkOutput("d037_rd_mem_wen", 64'(mem_wen), 64'h0);
        checkOutput("d037_rd_gnt1", 64'(gnt1), 64'h1);
        nextCycle();
        v[1] = 1'b0;
        applyStimulus();
        checkOutput("d037_rvalid1", 64'(rvalid1), 64'h1);
        checkOutput("d037_rdata1", 64'(rdata1), 64'hDEAD_BEEF);
        nextCycle();

        // Ten idle cycles: bus holds the last address with no write
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            checkOutput("d041_mem_wen", 64'(mem_wen), 64'h0);
            checkOutput("d041_mem_addr", 64'(mem_addr), 64'h5);
            nextCycle();
        end

        // Locked burst of six from requester 0 is cut after four to serve requester 1
        exp0_pat = 7'b1101111;
        exp1_pat = 7'b0010000;
        beats0   = 0;
        setReq(0, 1'b0, 32'h1, 32'h0, 1'b1);
        setReq(1, 1'b0, 32'h2, 32'h0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            applyStimulus();
            checkOutput("d038_gnt0", 64'(gnt0), 64'(exp0_pat[c]));
            checkOutput("d038_gnt1", 64'(gnt1), 64'(exp1_pat[c]));
            nextCycle();
            if (exp0_pat[c]) begin
                beats0++;
                if (beats0 == 6) v[0] = 1'b0;
                else a[0] = a[0] + 32'h1;
            end
            if (exp1_pat[c]) v[1] = 1'b0;
        end
        applyStimulus();
        nextCycle();

        // Owner drops valid mid-burst: the waiting requester is granted in that same cycle
        setReq(0, 1'b0, 32'h3, 32'h0, 1'b1);
        applyStimulus();
        checkOutput("d039_a_gnt0", 64'(gnt0), 64'h1);
        nextCycle();
        a[0] = 32'h4;
        setReq(1, 1'b0, 32'h6, 32'h0, 1'b0);
        applyStimulus();
        checkOutput("d039_b_gnt0", 64'(gnt0), 64'h1);
        checkOutput("d039_b_gnt1", 64'(gnt1), 64'h0);
        nextCycle();
        v[0] = 1'b0;
        applyStimulus();
        checkOutput("d039_c_gnt1", 64'(gnt1), 64'h1);
        checkOutput("d039_c_gnt0", 64'(gnt0), 64'h0);
        nextCycle();
        v[1] = 1'b0;
        applyStimulus();
        nextCycle();

        // Reset right after a granted read discards the response; next tie goes to requester 0
        setReq(0, 1'b0, 32'h7, 32'h0, 1'b0);
        applyStimulus();
        checkOutput("d040_gnt0", 64'(gnt0), 64'h1);
        nextCycle();
        doReset(2);
        setReq(0, 1'b0, 32'h8, 32'h0, 1'b0);
        setReq(1, 1'b0, 32'h9, 32'h0, 1'b0);
        applyStimulus();
        checkOutput("d040_tie_gnt0", 64'(gnt0), 64'h1);
        checkOutput("d040_rvalid0", 64'(rvalid0), 64'h0);
        nextCycle();
        v[0] = 1'b0;
        applyStimulus();
        nextCycle();
        clearRequests();

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset(1 + $urandom_range(0, 2));
            end else begin
                randomRequests();
                applyStimulus();
                nextCycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
